// File: rtl/conv_fixed_pkg.sv
// Fixed-point formats shared by the layer accumulators: product, bias, activation
// and accumulator widths, the alignment shift, and the accumulator state encoding.
package conv_fixed_pkg;

    localparam int CONV_PROD_W    = 14;
    localparam int CONV_PROD_FRAC = 8;
    localparam int CONV_BIAS_W    = 8;
    localparam int CONV_BIAS_FRAC = 4;
    localparam int CONV_OUT_W     = 8;
    localparam int CONV_OUT_FRAC  = 4;
    localparam int CONV_ACC_W     = 24;
    localparam int CONV_N_TERMS   = 25;
    // Accumulator carries product fraction bits; output and bias carry the same, fewer.
    localparam int CONV_SHIFT     = CONV_PROD_FRAC - CONV_OUT_FRAC;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_FINAL = 1'b1
    } acc_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational post-processing of a window sum: bias add, round half toward +inf,
// arithmetic shift to output format, saturate, optional ReLU.
module fixed_round_sat #(
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 8,
    parameter int SHIFT  = 4,
    parameter int OUT_W  = 8,
    parameter int RELU   = 1
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [BIAS_W-1:0] bias_i,
    output logic        [OUT_W-1:0]  res_o
);

    localparam int EW = ACC_W + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = ~MAX_V;
    localparam logic signed [EW-1:0] RND   = EW'(1) << (SHIFT-1);

    logic signed [EW-1:0] acc_x;
    logic signed [EW-1:0] bias_x;
    logic signed [EW-1:0] t;
    logic signed [EW-1:0] r;

    always_comb begin
        acc_x  = EW'(acc_i);
        bias_x = EW'(bias_i) <<< SHIFT;
        t      = acc_x + bias_x + RND;
        r      = t >>> SHIFT;
        if (r > MAX_V) begin
            res_o = MAX_V[OUT_W-1:0];
        end else if (r < MIN_V) begin
            res_o = MIN_V[OUT_W-1:0];
        end else begin
            res_o = r[OUT_W-1:0];
        end
        if (RELU != 0 && r[EW-1]) begin
            res_o = '0;
        end
    end

endmodule

// File: rtl/conv_product_accumulator.sv
// Sums N_TERMS signed products per window, adds the window bias and emits one
// rounded/saturated activation through a single decoupling result register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ACC   | accepting products; count tracks position within the window
// ST_FINAL | window complete; waits for the result register to be free
module conv_product_accumulator
    import conv_fixed_pkg::*;
#(
    parameter int PROD_W  = CONV_PROD_W,
    parameter int N_TERMS = CONV_N_TERMS,
    parameter int ACC_W   = CONV_ACC_W,
    parameter int BIAS_W  = CONV_BIAS_W,
    parameter int SHIFT   = CONV_SHIFT,
    parameter int OUT_W   = CONV_OUT_W,
    parameter int RELU    = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = cnt_width(N_TERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    acc_state_e               state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [BIAS_W-1:0] bias_q, bias_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     rdy_q;
    logic signed [ACC_W-1:0]  prod_x;
    logic [OUT_W-1:0]         res;

    assign prod_x     = ACC_W'($signed(prod_data));
    // rdy_q keeps prod_ready low through reset and for the edge that releases it.
    assign prod_ready = rdy_q && (state_q == ST_ACC);
    assign busy       = (count_q != '0) || (state_q == ST_FINAL);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    fixed_round_sat #(
        .ACC_W  (ACC_W),
        .BIAS_W (BIAS_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W),
        .RELU   (RELU)
    ) u_round_sat (
        .acc_i  (acc_q),
        .bias_i (bias_q),
        .res_o  (res)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            ST_ACC: begin
                if (clear) begin
                    count_d = '0;
                end else if (prod_valid && prod_ready) begin
                    if (count_q == '0) begin
                        acc_d  = prod_x;
                        bias_d = $signed(bias);
                    end else begin
                        acc_d = acc_q + prod_x;
                    end
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = ST_FINAL;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_FINAL: begin
                // Loading while the old result transfers keeps out_valid high with no gap.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = res;
                    out_valid_d = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_ACC;
            count_q     <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rdy_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_product_accumulator.sv
// Bench for conv_product_accumulator: instance A uses defaults (25 terms, ReLU),
// instance B uses one term without ReLU for rounding and signed-output cases.
module tb_conv_product_accumulator;

    localparam int PW = 14;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;

    logic          a_clear = 1'b0, a_pv = 1'b0, a_or = 1'b1;
    logic          a_pr, a_ov, a_busy;
    logic [PW-1:0] a_pd = '0;
    logic [7:0]    a_bias = '0;
    logic [7:0]    a_od;

    logic          b_clear = 1'b0, b_pv = 1'b0, b_or = 1'b1;
    logic          b_pr, b_ov, b_busy;
    logic [PW-1:0] b_pd = '0;
    logic [7:0]    b_bias = '0;
    logic [7:0]    b_od;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int win[0:63];
    int exp_q[$];
    int got_a[$];
    int got_b[$];
    int got_cyc[$];
    bit mon_en = 1'b0;

    conv_product_accumulator dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(a_clear),
        .prod_data(a_pd), .prod_valid(a_pv), .prod_ready(a_pr), .bias(a_bias),
        .out_data(a_od), .out_valid(a_ov), .out_ready(a_or), .busy(a_busy)
    );

    conv_product_accumulator #(.N_TERMS(1), .RELU(0)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(b_clear),
        .prod_data(b_pd), .prod_valid(b_pv), .prod_ready(b_pr), .bias(b_bias),
        .out_data(b_od), .out_valid(b_ov), .out_ready(b_or), .busy(b_busy)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        if (mon_en) begin
            if (a_ov && a_or) begin
                got_a.push_back(int'(a_od));
                got_cyc.push_back(cyc);
            end
            if (b_ov && b_or) got_b.push_back(int'(b_od));
        end
    end

    // Reference: exact sum, bias scaled by 16, floor((x+8)/16), clamp, optional ReLU.
    function automatic int model(input int n, input int bias_raw, input bit relu);
        longint s = 0;
        longint b;
        longint r;
        for (int i = 0; i < n; i++) s += win[i];
        b = (bias_raw > 127) ? bias_raw - 256 : bias_raw;
        s = s + b * 16 + 8;
        r = s / 16;
        if ((s % 16 != 0) && (s < 0)) r = r - 1;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        if (relu && r < 0) r = 0;
        return int'(r) & 255;
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive(input int inst, input bit v, input int d, input int bias_raw);
        if (inst == 0) begin
            a_pv = v; a_pd = PW'(d); a_bias = 8'(bias_raw);
        end else begin
            b_pv = v; b_pd = PW'(d); b_bias = 8'(bias_raw);
        end
    endtask

    function automatic bit pr_of(input int inst);
        return (inst == 0) ? a_pr : b_pr;
    endfunction

    task automatic fill(input int n, input int val);
        for (int i = 0; i < n; i++) win[i] = val;
    endtask

    task automatic fill_rand(input int n, input int mag);
        for (int i = 0; i < n; i++) win[i] = int'($urandom_range(0, 2 * mag)) - mag;
    endtask

    // Offers win[0..n-1]; bias is only meaningful with the first product, garbage otherwise.
    task automatic send_window(input int inst, input int n, input int bias_raw,
                               input bit rgap, input bit ror, output int used, output bit ok);
        int i = 0;
        used = 0;
        while (i < n && used < 2000) begin
            if (rgap && $urandom_range(0, 3) == 0) begin
                drive(inst, 1'b0, 0, int'($urandom_range(0, 255)));
            end else begin
                drive(inst, 1'b1, win[i], (i == 0) ? bias_raw : int'($urandom_range(0, 255)));
                if (pr_of(inst)) i++;
            end
            if (ror) begin
                if (inst == 0) a_or = 1'($urandom_range(0, 1));
                else b_or = 1'($urandom_range(0, 1));
            end
            tick();
            used++;
        end
        drive(inst, 1'b0, 0, 0);
        ok = (i == n);
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (a_pr !== 1'b0) begin bad++; $display("FAIL rst_a_ready: got %0d want 0", a_pr); end
        total++; if (b_pr !== 1'b0) begin bad++; $display("FAIL rst_b_ready: got %0d want 0", b_pr); end
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0d want 0", a_ov); end
        total++; if (a_od !== 8'd0) begin bad++; $display("FAIL rst_data: got %0d want 0", a_od); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0d want 0", a_busy); end
        ap_rst_n = 1'b1;
        tick();
        total++; if (a_pr !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %0d want 1", a_pr); end
        total++; if (b_pr !== 1'b1) begin bad++; $display("FAIL rst_release_b_ready: got %0d want 1", b_pr); end
    endtask

    task automatic test_basic();
        int used; bit ok;
        a_or = 1'b1;
        fill(25, 16);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got %0d want 1", ok); end
        total++; if (a_ov !== 1'b0 || a_pr !== 1'b0 || a_busy !== 1'b1)
            begin bad++; $display("FAIL basic_final: got ov=%0d pr=%0d busy=%0d want 0 0 1", a_ov, a_pr, a_busy); end
        tick();
        total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL basic_latency: got %0d want 1", a_ov); end
        total++; if (a_od !== 8'd25) begin bad++; $display("FAIL basic_data: got %0d want 25", a_od); end
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL basic_drain: got %0d want 0", a_ov); end
    endtask

    task automatic test_sat_bias();
        int used; bit ok;
        int pv[3] = '{8191, 0, 0};
        int bv[3] = '{127, 8'h10, 8'hF0};
        int wv[3] = '{127, 16, 0};
        for (int k = 0; k < 3; k++) begin
            fill(25, pv[k]);
            send_window(0, 25, bv[k], 1'b0, 1'b0, used, ok);
            tick();
            total++; if (!ok || a_ov !== 1'b1 || a_od !== 8'(wv[k]))
                begin bad++; $display("FAIL sat_bias_a%0d: got ov=%0d data=%0d want 1 %0d", k, a_ov, a_od, wv[k]); end
            tick();
        end
        win[0] = 0;
        send_window(1, 1, 8'hF0, 1'b0, 1'b0, used, ok);
        tick();
        total++; if (!ok || b_ov !== 1'b1 || b_od !== 8'hF0)
            begin bad++; $display("FAIL bias_norelu: got ov=%0d data=%0d want 1 240", b_ov, b_od); end
        tick();
    endtask

    task automatic test_round();
        int used; bit ok;
        int rp[4] = '{24, -24, -2000, -2100};
        int rw[4] = '{2, 255, 131, 128};
        b_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            win[0] = rp[k];
            send_window(1, 1, 0, 1'b0, 1'b0, used, ok);
            tick();
            total++; if (!ok || b_ov !== 1'b1 || b_od !== 8'(rw[k]))
                begin bad++; $display("FAIL round_%0d: got ov=%0d data=%0d want 1 %0d", rp[k], b_ov, b_od, rw[k]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int used; bit ok;
        a_or = 1'b0;
        fill(25, 16);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        tick();
        total++; if (!ok || a_ov !== 1'b1 || a_od !== 8'd25)
            begin bad++; $display("FAIL bp_first: got ov=%0d data=%0d want 1 25", a_ov, a_od); end
        fill(25, 32);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        total++; if (used !== 25) begin bad++; $display("FAIL bp_no_early_stall: got %0d want 25", used); end
        total++; if (a_pr !== 1'b0 || a_ov !== 1'b1 || a_od !== 8'd25)
            begin bad++; $display("FAIL bp_final_stall: got pr=%0d ov=%0d data=%0d want 0 1 25", a_pr, a_ov, a_od); end
        tick(); tick(); tick();
        total++; if (a_pr !== 1'b0 || a_od !== 8'd25)
            begin bad++; $display("FAIL bp_hold: got pr=%0d data=%0d want 0 25", a_pr, a_od); end
        a_or = 1'b1;
        tick();
        total++; if (a_ov !== 1'b1 || a_od !== 8'd50 || a_pr !== 1'b1)
            begin bad++; $display("FAIL bp_swap: got ov=%0d data=%0d pr=%0d want 1 50 1", a_ov, a_od, a_pr); end
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0d want 0", a_ov); end
    endtask

    task automatic test_clear();
        int used; bit ok;
        a_or = 1'b1;
        fill(10, 100);
        send_window(0, 10, 5, 1'b0, 1'b0, used, ok);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL clr_busy: got %0d want 1", a_busy); end
        drive(0, 1'b1, 100, 5); a_clear = 1'b1;
        tick();
        a_clear = 1'b0; drive(0, 1'b0, 0, 0);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL clr_idle: got %0d want 0", a_busy); end
        fill(25, 16);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        tick();
        total++; if (a_ov !== 1'b1 || a_od !== 8'd25)
            begin bad++; $display("FAIL clr_result: got ov=%0d data=%0d want 1 25", a_ov, a_od); end
        tick();
        fill(24, 16);
        send_window(0, 24, 0, 1'b0, 1'b0, used, ok);
        drive(0, 1'b1, 16, 0); a_clear = 1'b1;
        tick();
        a_clear = 1'b0; drive(0, 1'b0, 0, 0);
        total++; if (a_pr !== 1'b1 || a_busy !== 1'b0)
            begin bad++; $display("FAIL clr_last: got pr=%0d busy=%0d want 1 0", a_pr, a_busy); end
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL clr_last_noout: got %0d want 0", a_ov); end
        fill(25, 16);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        tick();
        total++; if (a_od !== 8'd25) begin bad++; $display("FAIL clr_after_last: got %0d want 25", a_od); end
        tick();
    endtask

    task automatic test_reset_mid();
        int used; bit ok;
        a_or = 1'b0;
        fill(25, 48);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        tick();
        fill(10, 16);
        send_window(0, 10, 0, 1'b0, 1'b0, used, ok);
        ap_rst_n = 1'b0;
        #1;
        total++; if (a_ov !== 1'b0 || a_od !== 8'd0 || a_pr !== 1'b0 || a_busy !== 1'b0)
            begin bad++; $display("FAIL rstmid_outputs: got ov=%0d data=%0d pr=%0d busy=%0d want 0 0 0 0", a_ov, a_od, a_pr, a_busy); end
        tick(); tick();
        ap_rst_n = 1'b1;
        a_or = 1'b1;
        tick();
        fill(25, 16);
        send_window(0, 25, 0, 1'b0, 1'b0, used, ok);
        tick();
        total++; if (!ok || a_ov !== 1'b1 || a_od !== 8'd25)
            begin bad++; $display("FAIL rstmid_result: got ov=%0d data=%0d want 1 25", a_ov, a_od); end
        tick();
    endtask

    task automatic test_back_to_back();
        int used; bit ok;
        a_or = 1'b1;
        exp_q.delete(); got_a.delete(); got_cyc.delete();
        mon_en = 1'b1;
        for (int w = 0; w < 3; w++) begin
            fill_rand(25, 60);
            exp_q.push_back(model(25, w * 20, 1'b1));
            send_window(0, 25, w * 20, 1'b0, 1'b0, used, ok);
            if (w > 0) begin
                total++; if (used !== 26) begin bad++; $display("FAIL b2b_cycles_%0d: got %0d want 26", w, used); end
            end
        end
        tick(); tick(); tick();
        mon_en = 1'b0;
        total++; if (got_a.size() !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", got_a.size()); end
        for (int k = 0; k < got_a.size() && k < 3; k++) begin
            total++; if (got_a[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_data_%0d: got %0d want %0d", k, got_a[k], exp_q[k]); end
            if (k > 0) begin
                total++; if (got_cyc[k] - got_cyc[k-1] !== 26)
                    begin bad++; $display("FAIL b2b_spacing_%0d: got %0d want 26", k, got_cyc[k] - got_cyc[k-1]); end
            end
        end
    endtask

    task automatic test_random();
        int used; bit ok;
        int mags[3] = '{60, 200, 8191};
        int bmags[3] = '{300, 2200, 8191};
        int bias_r;
        int guard;
        exp_q.delete(); got_a.delete(); got_b.delete(); got_cyc.delete();
        mon_en = 1'b1;
        for (int w = 0; w < 12; w++) begin
            fill_rand(25, mags[$urandom_range(0, 2)]);
            bias_r = int'($urandom_range(0, 255));
            exp_q.push_back(model(25, bias_r, 1'b1));
            send_window(0, 25, bias_r, 1'b1, 1'b1, used, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_a_timeout_%0d: got %0d want 1", w, ok); end
        end
        a_or = 1'b1;
        guard = 0;
        while (got_a.size() < exp_q.size() && guard < 100) begin tick(); guard++; end
        total++; if (got_a.size() !== exp_q.size())
            begin bad++; $display("FAIL rand_a_count: got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int k = 0; k < got_a.size() && k < exp_q.size(); k++) begin
            total++; if (got_a[k] !== exp_q[k]) begin bad++; $display("FAIL rand_a_data_%0d: got %0d want %0d", k, got_a[k], exp_q[k]); end
        end
        exp_q.delete();
        for (int w = 0; w < 30; w++) begin
            fill_rand(1, bmags[$urandom_range(0, 2)]);
            bias_r = int'($urandom_range(0, 255));
            exp_q.push_back(model(1, bias_r, 1'b0));
            send_window(1, 1, bias_r, 1'b1, 1'b1, used, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand_b_timeout_%0d: got %0d want 1", w, ok); end
        end
        b_or = 1'b1;
        guard = 0;
        while (got_b.size() < exp_q.size() && guard < 100) begin tick(); guard++; end
        mon_en = 1'b0;
        total++; if (got_b.size() !== exp_q.size())
            begin bad++; $display("FAIL rand_b_count: got %0d want %0d", got_b.size(), exp_q.size()); end
        for (int k = 0; k < got_b.size() && k < exp_q.size(); k++) begin
            total++; if (got_b[k] !== exp_q[k]) begin bad++; $display("FAIL rand_b_data_%0d: got %0d want %0d", k, got_b[k], exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_bias();
        test_round();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
